// File: rtl/alu_operand_stage.sv
// ID->EX operand stage: forwards register sources from EX/MEM/WB, selects both ALU
// operands, stalls on load-use hazards and registers the result behind a valid/ready handshake.
module alu_operand_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic                  in_uses_rs1,
    input  logic                  in_uses_rs2,
    input  logic [XLEN-1:0]       in_rs1_data,
    input  logic [XLEN-1:0]       in_rs2_data,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [4:0]            in_shamt,
    input  logic [XLEN-1:0]       in_pc,
    input  logic                  in_a_sel,
    input  logic [1:0]            in_b_sel,
    input  logic                  ex_wr_en,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]       ex_data,
    input  logic                  mem_wr_en,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    input  logic                  wb_wr_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_alu_in1,
    output logic [XLEN-1:0]       out_alu_in2,
    output logic [XLEN-1:0]       out_store_data,
    output logic [CNT_W-1:0]      bubble_cnt
);

    logic [REG_ADDR_W-1:0] src_addr [2];
    logic [XLEN-1:0]       rf_data  [2];
    logic [XLEN-1:0]       fwd_data [2];
    logic                  src_used [2];
    logic                  load_hit [2];

    assign src_addr[0] = in_rs1_addr;
    assign src_addr[1] = in_rs2_addr;
    assign rf_data[0]  = in_rs1_data;
    assign rf_data[1]  = in_rs2_data;
    assign src_used[0] = in_uses_rs1;
    assign src_used[1] = in_uses_rs2;

    // A load in EX has no data yet, so it never forwards; it stalls instead.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic ex_hit;
            logic mem_hit;
            logic wb_hit;
            assign ex_hit  = ex_wr_en & ~ex_is_load & (ex_rd == src_addr[gi]);
            assign mem_hit = mem_wr_en & (mem_rd == src_addr[gi]);
            assign wb_hit  = wb_wr_en & (wb_rd == src_addr[gi]);
            assign fwd_data[gi] = (src_addr[gi] == '0) ? '0 :
                                  ex_hit  ? ex_data  :
                                  mem_hit ? mem_data :
                                  wb_hit  ? wb_data  : rf_data[gi];
            assign load_hit[gi] = src_used[gi] & (ex_rd == src_addr[gi]);
        end
    endgenerate

    logic                 out_valid_reg;
    logic [XLEN-1:0]      alu_in1_reg;
    logic [XLEN-1:0]      alu_in2_reg;
    logic [XLEN-1:0]      store_data_reg;
    logic [CNT_W-1:0]     bubble_cnt_reg;

    logic                 load_use;
    logic                 capture;
    logic                 bubble_inc;
    logic [XLEN-1:0]      opa_next;
    logic [XLEN-1:0]      opb_next;

    assign load_use   = ex_wr_en & ex_is_load & (ex_rd != '0) & (load_hit[0] | load_hit[1]);
    assign in_ready   = ~flush & ~load_use & (~out_valid_reg | out_ready);
    assign capture    = in_valid & in_ready;
    assign bubble_inc = in_valid & load_use & ~flush;
    assign opa_next   = in_a_sel ? in_pc : fwd_data[0];

    always_comb begin
        opb_next = fwd_data[1];
        case (in_b_sel)
            2'b00:   opb_next = fwd_data[1];
            2'b01:   opb_next = in_imm;
            2'b10:   opb_next = {{(XLEN-5){1'b0}}, in_shamt};
            default: opb_next = XLEN'(4);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            alu_in1_reg    <= '0;
            alu_in2_reg    <= '0;
            store_data_reg <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (capture) begin
                out_valid_reg  <= 1'b1;
                alu_in1_reg    <= opa_next;
                alu_in2_reg    <= opb_next;
                store_data_reg <= fwd_data[1];
            end else if (flush || out_ready) begin
                out_valid_reg  <= 1'b0;
            end
            if (bubble_inc && (bubble_cnt_reg != {CNT_W{1'b1}})) begin
                bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign out_valid      = out_valid_reg;
    assign out_alu_in1    = alu_in1_reg;
    assign out_alu_in2    = alu_in2_reg;
    assign out_store_data = store_data_reg;
    assign bubble_cnt     = bubble_cnt_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed hazard/handshake scenarios followed by random
// traffic, all checked every cycle against a behavioural operand/handshake model.
module tb_alu_operand_stage;
    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, flush, in_valid, in_ready;
    logic [RAW-1:0]  in_rs1_addr, in_rs2_addr;
    logic            in_uses_rs1, in_uses_rs2;
    logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
    logic [4:0]      in_shamt;
    logic            in_a_sel;
    logic [1:0]      in_b_sel;
    logic            ex_wr_en, ex_is_load;
    logic [RAW-1:0]  ex_rd, mem_rd, wb_rd;
    logic [XLEN-1:0] ex_data, mem_data, wb_data;
    logic            mem_wr_en, wb_wr_en;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_alu_in1, out_alu_in2, out_store_data;
    logic [CW-1:0]   bubble_cnt;

    alu_operand_stage #(.XLEN(XLEN), .REG_ADDR_W(RAW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_shamt(in_shamt), .in_pc(in_pc), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data),
        .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_in1(out_alu_in1),
        .out_alu_in2(out_alu_in2), .out_store_data(out_store_data), .bubble_cnt(bubble_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: what the registered outputs must hold.
    logic            m_valid;
    logic [XLEN-1:0] m_in1, m_in2, m_sd;
    int              m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] fwd(input logic [RAW-1:0] src, input logic [XLEN-1:0] rf);
        if (src == 0) return '0;
        if (ex_wr_en && !ex_is_load && ex_rd == src) return ex_data;
        if (mem_wr_en && mem_rd == src) return mem_data;
        if (wb_wr_en && wb_rd == src) return wb_data;
        return rf;
    endfunction

    task automatic idle();
        rst = 0; flush = 0; in_valid = 0; out_ready = 1;
        in_rs1_addr = 0; in_rs2_addr = 0; in_uses_rs1 = 0; in_uses_rs2 = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_shamt = 0; in_pc = 0;
        in_a_sel = 0; in_b_sel = 0;
        ex_wr_en = 0; ex_is_load = 0; ex_rd = 0; ex_data = 0;
        mem_wr_en = 0; mem_rd = 0; mem_data = 0;
        wb_wr_en = 0; wb_rd = 0; wb_data = 0;
    endtask

    // One clock: check in_ready, advance the model across the edge, check outputs.
    task automatic cycle();
        logic lu, rdy, cap;
        logic [XLEN-1:0] a, b, sd;
        #2;
        lu = ex_wr_en && ex_is_load && ex_rd != 0 &&
             ((in_uses_rs1 && ex_rd == in_rs1_addr) || (in_uses_rs2 && ex_rd == in_rs2_addr));
        rdy = !flush && !lu && (!m_valid || out_ready);
        chk("in_ready", in_ready, rdy);
        a  = in_a_sel ? in_pc : fwd(in_rs1_addr, in_rs1_data);
        sd = fwd(in_rs2_addr, in_rs2_data);
        case (in_b_sel)
            2'd0:    b = sd;
            2'd1:    b = in_imm;
            2'd2:    b = 32'(in_shamt);
            default: b = 32'd4;
        endcase
        cap = in_valid && rdy;
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 0; m_in1 = 0; m_in2 = 0; m_sd = 0; m_cnt = 0;
        end else begin
            if (in_valid && lu && !flush && m_cnt < CMAX) m_cnt++;
            if (cap) begin
                m_valid = 1; m_in1 = a; m_in2 = b; m_sd = sd;
                $display("[TB] txn in1=0x%08h in2=0x%08h sd=0x%08h", a, b, sd);
            end else if (flush || out_ready) begin
                m_valid = 0;
            end
        end
        chk("out_valid", out_valid, m_valid);
        chk("bubble_cnt", bubble_cnt, m_cnt);
        if (m_valid || rst) begin
            chk("out_alu_in1", out_alu_in1, m_in1);
            chk("out_alu_in2", out_alu_in2, m_in2);
            chk("out_store_data", out_store_data, m_sd);
        end
    endtask

    initial begin
        m_valid = 0; m_in1 = 0; m_in2 = 0; m_sd = 0; m_cnt = 0;
        idle();
        rst = 1;
        cycle();
        cycle();
        chk("reset_valid", out_valid, 0);
        chk("reset_cnt", bubble_cnt, 0);
        chk("reset_in1", out_alu_in1, 0);
        rst = 0;

        // Forwarding priority on rs1 = x5
        in_valid = 1; in_rs1_addr = 5; in_uses_rs1 = 1; in_rs1_data = 32'h99;
        ex_wr_en = 1; ex_rd = 5; ex_data = 32'h11;
        mem_wr_en = 1; mem_rd = 5; mem_data = 32'h22;
        wb_wr_en = 1; wb_rd = 5; wb_data = 32'h33;
        cycle();
        chk("fwd_ex", out_alu_in1, 32'h11);
        ex_wr_en = 0;
        cycle();
        chk("fwd_mem", out_alu_in1, 32'h22);
        mem_wr_en = 0;
        cycle();
        chk("fwd_wb", out_alu_in1, 32'h33);

        // x0 guard
        idle();
        in_valid = 1; in_rs2_addr = 0; in_uses_rs2 = 1; in_rs2_data = 32'h1234;
        wb_wr_en = 1; wb_rd = 0; wb_data = 32'hFFFF; in_b_sel = 2'b00;
        cycle();
        chk("x0_in2", out_alu_in2, 0);
        chk("x0_store", out_store_data, 0);

        // Load-use stall then MEM forward
        idle();
        in_valid = 1; in_rs1_addr = 7; in_uses_rs1 = 1; in_rs1_data = 32'h5555;
        ex_wr_en = 1; ex_is_load = 1; ex_rd = 7;
        #1;
        chk("lu_ready", in_ready, 0);
        cycle();
        chk("lu_cnt", bubble_cnt, 1);
        ex_wr_en = 0; ex_is_load = 0;
        mem_wr_en = 1; mem_rd = 7; mem_data = 32'hABCD;
        cycle();
        chk("lu_fwd", out_alu_in1, 32'hABCD);
        chk("lu_valid", out_valid, 1);

        // Reset mid-transfer
        idle();
        out_ready = 0; rst = 1;
        cycle();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_cnt", bubble_cnt, 0);
        chk("midrst_in2", out_alu_in2, 0);

        // Back-pressure then flush
        idle();
        in_valid = 1; in_a_sel = 1; in_pc = 32'h2000; in_b_sel = 2'b11;
        cycle();
        out_ready = 0; in_pc = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_in1", out_alu_in1, 32'h2000);
            chk("hold_valid", out_valid, 1);
        end
        flush = 1;
        cycle();
        chk("flush_valid", out_valid, 0);
        chk("flush_in1", out_alu_in1, 32'h2000);

        // Operand B modes and PC operand A
        idle();
        in_valid = 1; in_b_sel = 2'b10; in_shamt = 5'd31;
        cycle();
        chk("shamt", out_alu_in2, 32'h0000001F);
        in_b_sel = 2'b11;
        cycle();
        chk("const4", out_alu_in2, 32'd4);
        in_a_sel = 1; in_pc = 32'h1000;
        cycle();
        chk("pc_a", out_alu_in1, 32'h1000);

        // Counter saturation
        idle();
        in_valid = 1; in_rs2_addr = 3; in_uses_rs2 = 1;
        ex_wr_en = 1; ex_is_load = 1; ex_rd = 3;
        for (int i = 0; i < CMAX + 3; i++) cycle();
        chk("sat_cnt", bubble_cnt, CMAX);
        cycle();
        chk("sat_hold", bubble_cnt, CMAX);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            in_rs1_addr = RAW'($urandom_range(0, 7));
            in_rs2_addr = RAW'($urandom_range(0, 7));
            in_uses_rs1 = 1'($urandom);
            in_uses_rs2 = 1'($urandom);
            in_rs1_data = $urandom;
            in_rs2_data = $urandom;
            in_imm      = $urandom;
            in_shamt    = 5'($urandom);
            in_pc       = $urandom;
            in_a_sel    = 1'($urandom);
            in_b_sel    = 2'($urandom);
            ex_wr_en    = 1'($urandom);
            ex_is_load  = ($urandom_range(0, 2) == 0);
            ex_rd       = RAW'($urandom_range(0, 7));
            ex_data     = $urandom;
            mem_wr_en   = 1'($urandom);
            mem_rd      = RAW'($urandom_range(0, 7));
            mem_data    = $urandom;
            wb_wr_en    = 1'($urandom);
            wb_rd       = RAW'($urandom_range(0, 7));
            wb_data     = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
